// File: rtl/vector_mac_axis.sv
// Dual-input AXI-Stream vector MAC. Each input has a one-beat hold register.
// When both holds are full, the pair goes through a three-stage pipeline:
// lane products, then an adder tree, then saturating accumulation and output
// scaling. One saturated result is emitted per packet, and the result output
// supports full backpressure.
module vector_mac_axis #(
    parameter int DATA_W    = 16,
    parameter int LANES     = 4,
    parameter int ACC_W     = 48,
    parameter int OUT_W     = 32,
    parameter int OUT_SHIFT = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [LANES*DATA_W-1:0] s_axis_a_tdata,
    input  logic                    s_axis_a_tvalid,
    output logic                    s_axis_a_tready,
    input  logic                    s_axis_a_tlast,
    input  logic [LANES*DATA_W-1:0] s_axis_b_tdata,
    input  logic                    s_axis_b_tvalid,
    output logic                    s_axis_b_tready,
    input  logic                    s_axis_b_tlast,
    input  logic                    clear,
    output logic [OUT_W-1:0]        m_axis_result_tdata,
    output logic                    m_axis_result_tvalid,
    input  logic                    m_axis_result_tready,
    output logic                    m_axis_result_tuser,
    output logic                    overflow,
    output logic                    tlast_err
);

    localparam int VEC_W  = LANES * DATA_W;
    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = PROD_W + $clog2(LANES);
    localparam int W      = (ACC_W > OUT_W) ? ACC_W : OUT_W;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [W-1:0] OUT_MAX = {{(W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [W-1:0] OUT_MIN = {{(W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic                    ready_en_reg;
    logic [VEC_W-1:0]        a_hold_reg, b_hold_reg;
    logic                    a_last_reg, b_last_reg;
    logic                    a_full_reg, b_full_reg;
    logic                    s1_valid_reg, s1_last_reg;
    logic [LANES*PROD_W-1:0] prod_flat;
    logic                    s2_valid_reg, s2_last_reg;
    logic signed [SUM_W-1:0] sum_reg, sum_next;
    logic signed [ACC_W-1:0] acc_reg, acc_next;
    logic signed [ACC_W:0]   acc_wide;
    logic                    acc_clamp;
    logic signed [ACC_W-1:0] shifted;
    logic signed [W-1:0]     shifted_w;
    logic [OUT_W-1:0]        out_sat;
    logic                    out_clamp;
    logic                    pkt_sat_reg;
    logic [OUT_W-1:0]        out_data_reg;
    logic                    out_valid_reg, out_user_reg;
    logic                    overflow_reg, tlast_err_reg;

    logic adv, fire, a_accept, b_accept;

    // The pipeline only holds still while an undrained result blocks the output.
    assign adv      = ~(out_valid_reg & ~m_axis_result_tready);
    assign fire     = a_full_reg & b_full_reg & adv;
    assign s_axis_a_tready = ready_en_reg & ~a_full_reg & ~clear;
    assign s_axis_b_tready = ready_en_reg & ~b_full_reg & ~clear;
    assign a_accept = s_axis_a_tvalid & s_axis_a_tready;
    assign b_accept = s_axis_b_tvalid & s_axis_b_tready;

    assign m_axis_result_tdata  = out_data_reg;
    assign m_axis_result_tvalid = out_valid_reg;
    assign m_axis_result_tuser  = out_user_reg;
    assign overflow             = overflow_reg;
    assign tlast_err            = tlast_err_reg;

    // The treadys stay low in reset and rise on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_en_reg <= 1'b0;
        else        ready_en_reg <= 1'b1;
    end

    // Hold registers: each fills on its own handshake and empties when the pair fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_full_reg <= 1'b0; a_hold_reg <= '0; a_last_reg <= 1'b0;
            b_full_reg <= 1'b0; b_hold_reg <= '0; b_last_reg <= 1'b0;
        end else if (clear) begin
            a_full_reg <= 1'b0;
            b_full_reg <= 1'b0;
        end else begin
            if (a_accept) begin
                a_full_reg <= 1'b1;
                a_hold_reg <= s_axis_a_tdata;
                a_last_reg <= s_axis_a_tlast;
            end else if (fire) begin
                a_full_reg <= 1'b0;
            end
            if (b_accept) begin
                b_full_reg <= 1'b1;
                b_hold_reg <= s_axis_b_tdata;
                b_last_reg <= s_axis_b_tlast;
            end else if (fire) begin
                b_full_reg <= 1'b0;
            end
        end
    end

    // Stage 1 control: the valid bit and the merged last flag for the fired pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
        end else if (clear) begin
            s1_valid_reg <= 1'b0;
        end else if (adv) begin
            s1_valid_reg <= fire;
            s1_last_reg  <= a_last_reg | b_last_reg;
        end
    end

    // Mismatched tlast flags on a fired pair set a sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 tlast_err_reg <= 1'b0;
        else if (clear)                             tlast_err_reg <= 1'b0;
        else if (fire && (a_last_reg != b_last_reg)) tlast_err_reg <= 1'b1;
    end

    // Stage 1 data: one registered signed product per lane.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : gen_lane
            logic signed [PROD_W-1:0] prod_reg;
            logic signed [PROD_W-1:0] prod_next;
            assign prod_next = $signed(a_hold_reg[gi*DATA_W +: DATA_W]) *
                               $signed(b_hold_reg[gi*DATA_W +: DATA_W]);
            assign prod_flat[gi*PROD_W +: PROD_W] = prod_reg;
            // Capture this lane's product when the pair fires.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)           prod_reg <= '0;
                else if (adv && fire) prod_reg <= prod_next;
            end
        end
    endgenerate

    // Adder tree over the lane products. It is wide enough that it can never overflow.
    always_comb begin
        sum_next = '0;
        for (int i = 0; i < LANES; i++)
            sum_next = sum_next + SUM_W'($signed(prod_flat[i*PROD_W +: PROD_W]));
    end

    // Stage 2: register the beat sum and its last flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_last_reg  <= 1'b0;
            sum_reg      <= '0;
        end else if (clear) begin
            s2_valid_reg <= 1'b0;
        end else if (adv) begin
            s2_valid_reg <= s1_valid_reg;
            s2_last_reg  <= s1_last_reg;
            sum_reg      <= sum_next;
        end
    end

    // Saturating accumulate, then floor shift and saturation to the output width.
    always_comb begin
        acc_wide  = (ACC_W+1)'(acc_reg) + (ACC_W+1)'(sum_reg);
        acc_clamp = acc_wide[ACC_W] ^ acc_wide[ACC_W-1];
        if (acc_clamp) acc_next = acc_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        else           acc_next = acc_wide[ACC_W-1:0];
        shifted   = acc_next >>> OUT_SHIFT;
        shifted_w = W'(shifted);
        out_clamp = 1'b0;
        out_sat   = shifted_w[OUT_W-1:0];
        if (shifted_w > OUT_MAX) begin
            out_clamp = 1'b1;
            out_sat   = OUT_MAX[OUT_W-1:0];
        end else if (shifted_w < OUT_MIN) begin
            out_clamp = 1'b1;
            out_sat   = OUT_MIN[OUT_W-1:0];
        end
    end

    // Stage 3: accumulate, or on last emit the result and restart the packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0; pkt_sat_reg <= 1'b0;
            out_data_reg <= '0; out_valid_reg <= 1'b0; out_user_reg <= 1'b0;
            overflow_reg <= 1'b0;
        end else if (clear) begin
            acc_reg <= '0; pkt_sat_reg <= 1'b0;
            out_data_reg <= '0; out_valid_reg <= 1'b0; out_user_reg <= 1'b0;
            overflow_reg <= 1'b0;
        end else if (adv) begin
            if (s2_valid_reg && s2_last_reg) begin
                out_data_reg  <= out_sat;
                out_user_reg  <= pkt_sat_reg | acc_clamp | out_clamp;
                overflow_reg  <= overflow_reg | pkt_sat_reg | acc_clamp | out_clamp;
                out_valid_reg <= 1'b1;
                acc_reg       <= '0;
                pkt_sat_reg   <= 1'b0;
            end else begin
                out_valid_reg <= 1'b0;
                if (s2_valid_reg) begin
                    acc_reg     <= acc_next;
                    pkt_sat_reg <= pkt_sat_reg | acc_clamp;
                end
            end
        end
    end

endmodule

// File: tb/tb_vector_mac_axis.sv
// Bench for vector_mac_axis. It drives two instances with the same stimulus:
// one with the default accumulator width and one with ACC_W=34. A saturating
// reference model pushes the expected results into one scoreboard queue per
// instance, and monitors pop and compare the results as the DUTs emit them.
module tb_vector_mac_axis;

    logic        clk = 1'b0;
    logic        rst_n, clear, rtready;
    logic [63:0] a_data, b_data;
    logic        a_valid, a_last, b_valid, b_last;

    logic [1:0]  a_rdy, b_rdy, rvalid, ruser, ovf, terr;
    logic [31:0] rdata [2];

    int errors = 0;
    int checks = 0;

    logic [32:0] q0 [$];
    logic [32:0] q1 [$];
    longint      m_acc  [2];
    bit          m_flag [2];
    bit          m_ovf  [2];
    bit          m_err;
    int          accw   [2] = '{48, 34};

    always #5 clk = ~clk;

    vector_mac_axis dut0 (
        .clk(clk), .rst_n(rst_n),
        .s_axis_a_tdata(a_data), .s_axis_a_tvalid(a_valid), .s_axis_a_tready(a_rdy[0]), .s_axis_a_tlast(a_last),
        .s_axis_b_tdata(b_data), .s_axis_b_tvalid(b_valid), .s_axis_b_tready(b_rdy[0]), .s_axis_b_tlast(b_last),
        .clear(clear),
        .m_axis_result_tdata(rdata[0]), .m_axis_result_tvalid(rvalid[0]),
        .m_axis_result_tready(rtready), .m_axis_result_tuser(ruser[0]),
        .overflow(ovf[0]), .tlast_err(terr[0])
    );

    vector_mac_axis #(.ACC_W(34)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .s_axis_a_tdata(a_data), .s_axis_a_tvalid(a_valid), .s_axis_a_tready(a_rdy[1]), .s_axis_a_tlast(a_last),
        .s_axis_b_tdata(b_data), .s_axis_b_tvalid(b_valid), .s_axis_b_tready(b_rdy[1]), .s_axis_b_tlast(b_last),
        .clear(clear),
        .m_axis_result_tdata(rdata[1]), .m_axis_result_tvalid(rvalid[1]),
        .m_axis_result_tready(rtready), .m_axis_result_tuser(ruser[1]),
        .overflow(ovf[1]), .tlast_err(terr[1])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic longint sat(input longint v, input int w, output bit c);
        longint mx, mn;
        mx = (longint'(1) <<< (w - 1)) - 1;
        mn = -mx - 1;
        c  = 1'b0;
        if (v > mx) begin c = 1'b1; return mx; end
        if (v < mn) begin c = 1'b1; return mn; end
        return v;
    endfunction

    task automatic model_beat(input logic [63:0] av, input logic [63:0] bv, input logic al, input logic bl);
        longint sum, v, o;
        bit     c1, c2, f;
        logic [32:0] e;
        sum = 0;
        for (int i = 0; i < 4; i++)
            sum += longint'($signed(av[i*16 +: 16])) * longint'($signed(bv[i*16 +: 16]));
        if (al != bl) m_err = 1'b1;
        for (int k = 0; k < 2; k++) begin
            v = sat(m_acc[k] + sum, accw[k], c1);
            f = m_flag[k] | c1;
            if (al | bl) begin
                o = sat(v >>> 8, 32, c2);
                f = f | c2;
                e = {f, o[31:0]};
                if (k == 0) q0.push_back(e); else q1.push_back(e);
                m_ovf[k]  = m_ovf[k] | f;
                m_acc[k]  = 0;
                m_flag[k] = 1'b0;
            end else begin
                m_acc[k]  = v;
                m_flag[k] = f;
            end
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_acc[k] = 0; m_flag[k] = 1'b0; m_ovf[k] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    // Result monitors: sample before the edge on which the handshake completes.
    always @(negedge clk) begin
        logic [32:0] e;
        for (int k = 0; k < 2; k++) begin
            if (rst_n && rvalid[k] && rtready) begin
                $display("RES dut%0d data=%08h user=%0d", k, rdata[k], ruser[k]);
                if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                    chk("spurious_result", 1, 0);
                end else begin
                    e = (k == 0) ? q0.pop_front() : q1.pop_front();
                    chk("res_data", rdata[k], e[31:0]);
                    chk("res_user", ruser[k], e[32]);
                end
            end
        end
    end

    task automatic drive_a(input logic [63:0] v, input logic l);
        bit done = 1'b0;
        a_data = v; a_last = l; a_valid = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (a_rdy[0]) begin
                chk("a_rdy_match", a_rdy[1], 1);
                @(posedge clk); #1;
                done = 1'b1;
            end
        end
        a_valid = 1'b0;
        if (!done) chk("a_accept_timeout", done, 1);
    endtask

    task automatic drive_b(input logic [63:0] v, input logic l);
        bit done = 1'b0;
        b_data = v; b_last = l; b_valid = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (b_rdy[0]) begin
                chk("b_rdy_match", b_rdy[1], 1);
                @(posedge clk); #1;
                done = 1'b1;
            end
        end
        b_valid = 1'b0;
        if (!done) chk("b_accept_timeout", done, 1);
    endtask

    task automatic send_pair(input logic [63:0] av, input logic [63:0] bv, input logic al, input logic bl);
        fork
            drive_a(av, al);
            drive_b(bv, bl);
        join
        model_beat(av, bv, al, bl);
        $display("PAIR a=%016h b=%016h alast=%0d blast=%0d", av, bv, al, bl);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 500) begin
            @(posedge clk); #1; n++;
        end
        if (q0.size() != 0 || q1.size() != 0) chk("drain_timeout", n, 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_overflow"}, ovf[k], m_ovf[k]);
            chk({tag, "_tlast_err"}, terr[k], m_err);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        model_clear();
        @(negedge clk);
        chk("rst_a_ready", a_rdy[0], 0);
        chk("rst_b_ready", b_rdy[0], 0);
        chk("rst_tvalid", rvalid[0], 0);
        chk("rst_tdata", rdata[0], 0);
        chk("rst_overflow", ovf[0], 0);
        chk("rst_tlast_err", terr[0], 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready_pre_edge", a_rdy[0], 0);
        @(posedge clk); #1;
        chk("rel_a_ready", a_rdy[0], 1);
        chk("rel_b_ready", b_rdy[0], 1);
    endtask

    task automatic check_latency(input logic [31:0] exp);
        repeat (2) @(posedge clk);
        #1 chk("lat_not_early", rvalid[0], 0);
        @(posedge clk);
        #1 chk("lat_valid", rvalid[0], 1);
        chk("lat_data", rdata[0], {32'd0, exp});
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        logic [63:0] av, bv;
        int len;
        rst_n = 1'b0; clear = 1'b0; rtready = 1'b1;
        a_data = '0; b_data = '0; a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0; b_last = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        do_reset();

        // Single-beat packet. Both inputs offer the beat on the same cycle.
        send_pair(64'h0100010001000100, 64'h0200020002000200, 1, 1);
        check_latency(32'h800);
        wait_drain();
        check_flags("t1");

        // A arrives alone, and B follows three cycles later.
        drive_a(64'h0100010001000100, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("a_ready_while_full", a_rdy[0], 0);
        end
        @(posedge clk); #1;
        drive_b(64'h0100010001000100, 1);
        model_beat(64'h0100010001000100, 64'h0100010001000100, 1, 1);
        check_latency(32'h400);
        wait_drain();

        // Three-beat packet, then a single-beat packet that starts from zero.
        send_pair(64'h0100010001000100, 64'h0100010001000100, 0, 0);
        send_pair(64'h0100010001000100, 64'h0100010001000100, 0, 0);
        send_pair(64'h0100010001000100, 64'h0100010001000100, 1, 1);
        send_pair(64'h0100010001000100, 64'h0200020002000200, 1, 1);
        wait_drain();

        // Backpressure: the first result is held while later beats fill the holds.
        rtready = 1'b0;
        send_pair(64'h0100010001000100, 64'h0100010001000100, 1, 1);
        send_pair(64'h0100010001000100, 64'h0200020002000200, 1, 1);
        send_pair(64'h0100010001000100, 64'h0300030003000300, 1, 1);
        repeat (3) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_tvalid", rvalid[0], 1);
            chk("stall_tdata", rdata[0], 32'h400);
            chk("stall_a_ready", a_rdy[0], 0);
            chk("stall_b_ready", b_rdy[0], 0);
        end
        @(posedge clk); #1;
        rtready = 1'b1;
        wait_drain();

        // Three near-full-scale beats. They saturate the 34-bit accumulator but not the 48-bit one.
        for (int i = 0; i < 3; i++)
            send_pair(64'h7FFF7FFF7FFF7FFF, 64'h7FFF7FFF7FFF7FFF, i == 2, i == 2);
        wait_drain();
        check_flags("t4");
        send_pair(64'h0100010001000100, 64'h0100010001000100, 1, 1);
        wait_drain();
        check_flags("t4_sticky");

        // Random mixed-sign packets.
        for (int p = 0; p < 5; p++) begin
            len = $urandom_range(1, 3);
            for (int j = 0; j < len; j++) begin
                av = {$urandom(), $urandom()};
                bv = {$urandom(), $urandom()};
                send_pair(av, bv, j == len - 1, j == len - 1);
            end
        end
        wait_drain();
        check_flags("rand");

        // A clear mid-packet. A beat offered during the clear must not be taken.
        send_pair(64'h0100010001000100, 64'h0100010001000100, 0, 0);
        @(posedge clk); #1;
        clear = 1'b1;
        a_data = 64'h7FFF7FFF7FFF7FFF; a_last = 1'b1; a_valid = 1'b1;
        @(negedge clk);
        chk("clear_a_ready", a_rdy[0], 0);
        chk("clear_b_ready", b_rdy[0], 0);
        @(posedge clk); #1;
        clear = 1'b0; a_valid = 1'b0;
        model_clear();
        repeat (8) @(posedge clk);
        #1 check_flags("after_clear");
        chk("after_clear_tvalid", rvalid[0], 0);
        send_pair(64'h0100010001000100, 64'h0200020002000200, 1, 1);
        wait_drain();

        // A reset mid-packet discards the partial sum.
        send_pair(64'h0100010001000100, 64'h0100010001000100, 0, 0);
        @(posedge clk);
        do_reset();
        repeat (8) @(posedge clk);
        #1 check_flags("after_reset");
        send_pair(64'h0100010001000100, 64'h0100010001000100, 1, 1);
        wait_drain();

        // Mismatched tlast flags still close the packet and set the sticky error.
        send_pair(64'h0100010001000100, 64'h0300030003000300, 1, 0);
        wait_drain();
        check_flags("tlast_mismatch");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
